// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: shared widths, idle levels and the seven-segment glyph table
package sevenseg_pkg;
    localparam int DIGITS = 8;
    localparam int SEG_W  = 7;
    localparam int HEX_W  = 4;
    localparam logic [DIGITS-1:0] ANODE_IDLE = '1;
    localparam logic [SEG_W-1:0]  SEG_IDLE   = '1;
    // active-high gfedcba patterns, index = hex value
    localparam logic [15:0][SEG_W-1:0] GLYPHS = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };
endpackage

// File: rtl/seg_decode.sv
// seg_decode: active-high segment pattern to hex nibble plus legal-glyph flag
module seg_decode
    import sevenseg_pkg::*;
(
    input  logic [SEG_W-1:0] seg,
    output logic [HEX_W-1:0] hex,
    output logic             ok
);
    always_comb begin
        hex = '0;
        ok  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg == GLYPHS[i]) begin
                hex = HEX_W'(i);
                ok  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/sevenseg_capture.sv
// sevenseg_capture: debounces a multiplexed 7-segment display bus into per-digit
// hex values with refresh tracking and a change pulse.
module sevenseg_capture
    import sevenseg_pkg::*;
#(
    parameter int STABLE_CYCLES = 16,
    parameter int STALE_CYCLES  = 1048576
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DIGITS-1:0]       anode,
    input  logic [SEG_W-1:0]        cathode,
    input  logic                    dp,
    output logic [DIGITS*HEX_W-1:0] hex_out,
    output logic [DIGITS-1:0]       dp_out,
    output logic [DIGITS-1:0]       digit_ok,
    output logic [DIGITS-1:0]       digit_valid,
    output logic                    update,
    output logic                    multi_err
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int PW = $clog2(STALE_CYCLES + 1);

    logic [DIGITS-1:0]       s_anode, sel, cap_mask, refreshed;
    logic [SEG_W-1:0]        s_cathode, seg;
    logic                    s_dp, same, cap, one_hot, multi, wrap, dec_ok;
    logic [CW-1:0]           cnt;
    logic [PW-1:0]           pcnt;
    logic [HEX_W-1:0]        dec_hex;
    logic [DIGITS*HEX_W-1:0] hex_next;
    logic [DIGITS-1:0]       dp_next, ok_next;

    assign seg = ~s_cathode;

    seg_decode u_dec (.seg(seg), .hex(dec_hex), .ok(dec_ok));

    assign same     = {anode, cathode, dp} == {s_anode, s_cathode, s_dp};
    // counter saturates above STABLE_CYCLES-1, so each stable period captures once
    assign cap      = cnt == CW'(STABLE_CYCLES - 1);
    assign sel      = ~s_anode;
    assign one_hot  = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
    assign multi    = (sel != '0) && !one_hot;
    assign cap_mask = (cap && one_hot) ? sel : '0;
    assign wrap     = pcnt == PW'(STALE_CYCLES - 1);

    always_comb begin
        hex_next = hex_out;
        dp_next  = dp_out;
        ok_next  = digit_ok;
        for (int i = 0; i < DIGITS; i++) begin
            if (cap_mask[i]) begin
                hex_next[HEX_W*i +: HEX_W] = dec_hex;
                dp_next[i]                 = ~s_dp;
                ok_next[i]                 = dec_ok;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_anode     <= ANODE_IDLE;
            s_cathode   <= SEG_IDLE;
            s_dp        <= 1'b1;
            cnt         <= '0;
            pcnt        <= '0;
            hex_out     <= '0;
            dp_out      <= '0;
            digit_ok    <= '0;
            digit_valid <= '0;
            refreshed   <= '0;
            update      <= 1'b0;
            multi_err   <= 1'b0;
        end else begin
            s_anode     <= anode;
            s_cathode   <= cathode;
            s_dp        <= dp;
            cnt         <= !same ? '0 : (cnt < CW'(STABLE_CYCLES)) ? cnt + 1'b1 : cnt;
            pcnt        <= wrap ? '0 : pcnt + 1'b1;
            hex_out     <= hex_next;
            dp_out      <= dp_next;
            digit_ok    <= ok_next;
            update      <= {hex_next, dp_next, ok_next} != {hex_out, dp_out, digit_ok};
            multi_err   <= multi_err | (cap && multi);
            // a capture on the wrap edge counts for both the closing and the new period
            digit_valid <= wrap ? (refreshed | cap_mask) : digit_valid;
            refreshed   <= wrap ? cap_mask : (refreshed | cap_mask);
        end
    end
endmodule

// File: tb/tb_sevenseg_capture.sv
// tb_sevenseg_capture: directed table-driven checks of capture timing, decode,
// refresh tracking, glitch rejection and reset behaviour.
module tb_sevenseg_capture;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  anode = 8'hFF;
    logic [6:0]  cathode = 7'h7F;
    logic        dp = 1'b1;
    logic [31:0] hex_out;
    logic [7:0]  dp_out, digit_ok, digit_valid;
    logic        update, multi_err;

    int tests = 0;
    int fails = 0;

    sevenseg_capture #(.STABLE_CYCLES(16), .STALE_CYCLES(400)) dut (
        .clk(clk), .rst_n(rst_n), .anode(anode), .cathode(cathode), .dp(dp),
        .hex_out(hex_out), .dp_out(dp_out), .digit_ok(digit_ok),
        .digit_valid(digit_valid), .update(update), .multi_err(multi_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dpon;
        int         dig;
        logic [3:0] hx;
        logic       ok;
    } vec_t;

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [6:0] scan_seg [8] = '{7'h06, 7'h5B, 7'h4F, 7'h66, 7'h77, 7'h7C, 7'h39, 7'h5E};
    vec_t vecs [18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] a, input logic [6:0] s, input logic d_on);
        @(negedge clk);
        anode   = a;
        cathode = ~s;
        dp      = ~d_on;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hold(input int n, output int pulses, output int first);
        pulses = 0;
        first  = -1;
        for (int e = 1; e <= n; e++) begin
            @(posedge clk);
            #1;
            if (update) begin
                pulses++;
                if (first < 0) first = e;
            end
        end
    endtask

    task automatic scan(input int n, input int skip);
        for (int s = 0; s < n; s++)
            for (int d = 0; d < 8; d++) begin
                drive(d == skip ? 8'hFF : ~(8'd1 << d), scan_seg[d], 1'b0);
                step(20);
            end
    endtask

    initial begin
        int p, f;
        logic [31:0] saved;
        for (int i = 0; i < 16; i++)
            vecs[i] = '{~(8'd1 << (i % 8)), glyph[i], 1'(i % 2), i % 8, 4'(i), 1'b1};
        vecs[16] = '{8'hF7, 7'h01, 1'b0, 3, 4'h0, 1'b0};
        vecs[17] = '{8'hBF, 7'h00, 1'b1, 6, 4'h0, 1'b0};

        #12;
        chk("reset hex", hex_out, 32'h0);
        chk("reset flags", {dp_out, digit_ok, digit_valid, 6'b0, update, multi_err}, 32'h0);
        @(negedge clk) rst_n = 1'b1;

        // capture landing exactly on the first period wrap (edge 400)
        step(383);
        drive(8'hFB, 7'h4F, 1'b0);
        step(16);
        chk("pre-wrap valid", {24'h0, digit_valid}, 32'h0);
        chk("pre-wrap update", {31'h0, update}, 32'h0);
        step(1);
        chk("wrap valid", {24'h0, digit_valid}, 32'h04);
        chk("wrap hex", hex_out, 32'h0000_0300);
        chk("wrap update", {31'h0, update}, 32'h1);
        drive(8'hFF, 7'h00, 1'b0);
        step(400);
        chk("carried valid", {24'h0, digit_valid}, 32'h04);
        step(400);
        chk("stale valid", {24'h0, digit_valid}, 32'h00);

        // single digit, update latency
        drive(8'hFE, 7'h5B, 1'b1);
        hold(20, p, f);
        chk("lat first", f, 17);
        chk("lat pulses", p, 1);
        chk("lat hex0", {28'h0, hex_out[3:0]}, 32'h2);
        chk("lat dp0", {31'h0, dp_out[0]}, 32'h1);
        chk("lat ok0", {31'h0, digit_ok[0]}, 32'h1);

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].an, vecs[i].seg, vecs[i].dpon);
            step(20);
            chk($sformatf("vec%0d hex", i), {28'h0, hex_out[4*vecs[i].dig +: 4]}, {28'h0, vecs[i].hx});
            chk($sformatf("vec%0d ok", i), {31'h0, digit_ok[vecs[i].dig]}, {31'h0, vecs[i].ok});
            chk($sformatf("vec%0d dp", i), {31'h0, dp_out[vecs[i].dig]}, {31'h0, vecs[i].dpon});
        end

        // short glitch never captures
        saved = hex_out;
        drive(8'hFB, 7'h66, 1'b0);
        hold(10, p, f);
        chk("glitch pulses a", p, 0);
        drive(8'hFF, 7'h7F, 1'b0);
        hold(20, p, f);
        chk("glitch pulses b", p, 0);
        chk("glitch hex", hex_out, saved);

        // identical rewrite gives no pulse
        drive(8'hFD, 7'h7F, 1'b0);
        step(20);
        drive(8'hFF, 7'h00, 1'b0);
        step(3);
        drive(8'hFD, 7'h7F, 1'b0);
        hold(20, p, f);
        chk("rewrite pulses", p, 0);
        chk("rewrite hex1", {28'h0, hex_out[7:4]}, 32'h8);

        // two anodes low
        saved = hex_out;
        chk("multi before", {31'h0, multi_err}, 32'h0);
        drive(8'hFC, 7'h06, 1'b0);
        step(20);
        chk("multi err", {31'h0, multi_err}, 32'h1);
        chk("multi hex", hex_out, saved);

        // full scan, then scan with digit 5 missing
        scan(6, -1);
        chk("scan hex", hex_out, 32'hDCBA_4321);
        chk("scan ok", {24'h0, digit_ok}, 32'hFF);
        chk("scan dp", {24'h0, dp_out}, 32'h00);
        chk("scan valid", {24'h0, digit_valid}, 32'hFF);
        scan(6, 5);
        chk("skip valid", {24'h0, digit_valid}, 32'hDF);
        chk("skip hex", hex_out, 32'hDCBA_4321);

        // asynchronous reset in the middle of a stable count
        drive(8'hF7, 7'h66, 1'b0);
        step(8);
        #2 rst_n = 1'b0;
        #1;
        chk("async hex", hex_out, 32'h0);
        chk("async flags", {dp_out, digit_ok, digit_valid, 6'b0, update, multi_err}, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        hold(20, p, f);
        chk("recap first", f, 17);
        chk("recap pulses", p, 1);
        chk("recap hex", hex_out, 32'h0000_4000);
        chk("recap valid", {24'h0, digit_valid}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
